// File: rtl/uart_io_module.sv
// ---------------------------------------------------------------------------
// uart_io_module
//   UART-to-memory bridge between the board UART pins and a single-port BRAM.
//   Receive mode: 8N1 bytes arriving on rx are paired into 16-bit words
//   (first byte = low half) and written to consecutive BRAM addresses.
//   Send mode: every stored word is read back and transmitted on tx,
//   low byte first, as 8N1 frames.
//
// Ports
//   clk_100          system clock, the only clock
//   rst_n            asynchronous active-low reset
//   rx / tx          UART serial in / out, both idle high
//   data_in_io       BRAM read data (1-cycle registered read latency)
//   data_out_io      BRAM write data
//   addr_io          BRAM address (write address in receive, read pointer in send)
//   we_io            BRAM write enable, single-cycle pulse per packed word
//   ctrl_io_receive  level, enables reception
//   ctrl_io_send     rising edge starts a transmit session
//   led_rx / led_tx  RX / TX state machine busy indicators
// ---------------------------------------------------------------------------
module uart_io_module #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 16
) (
  input  logic              clk_100,
  input  logic              rst_n,
  input  logic              rx,
  output logic              tx,
  input  logic [15:0]       data_in_io,
  output logic [15:0]       data_out_io,
  output logic [ADDR_W-1:0] addr_io,
  output logic              we_io,
  input  logic              ctrl_io_receive,
  input  logic              ctrl_io_send,
  output logic              led_rx,
  output logic              led_tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_READ, TX_LATCH, TX_START, TX_DATA, TX_STOP} tx_state_t;

  rx_state_t         rx_state_reg;
  tx_state_t         tx_state_reg;

  // rx synchroniser plus one extra stage for falling-edge detection
  logic              rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic              send_prev_reg;
  logic              send_rise;

  logic [CNT_W-1:0]  rx_cnt_reg;
  logic [2:0]        rx_bit_reg;
  logic [7:0]        rx_shift_reg;
  logic [7:0]        rx_byte;
  logic              byte_phase_reg;
  logic [7:0]        low_byte_reg;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [ADDR_W:0]   word_cnt_reg;   // one extra bit so a full memory is representable
  logic [15:0]       data_out_reg;
  logic              we_reg;

  logic [CNT_W-1:0]  tx_cnt_reg;
  logic [2:0]        tx_bit_reg;
  logic [7:0]        tx_shift_reg;
  logic [7:0]        tx_hi_byte_reg;
  logic              tx_hi_sel_reg;
  logic [ADDR_W:0]   rd_ptr_reg;
  logic [ADDR_W:0]   rd_next;
  logic              tx_reg;

  assign send_rise = ctrl_io_send & ~send_prev_reg;
  assign rd_next   = rd_ptr_reg + 1'b1;
  // The byte completes with the bit being sampled on this cycle.
  assign rx_byte   = {rx_sync_reg, rx_shift_reg[7:1]};

  // -------------------------------------------------------------------------
  // Input synchronisation and edge history
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg   <= 1'b1;
      rx_sync_reg   <= 1'b1;
      rx_prev_reg   <= 1'b1;
      send_prev_reg <= 1'b0;
    end else begin
      rx_meta_reg   <= rx;
      rx_sync_reg   <= rx_meta_reg;
      rx_prev_reg   <= rx_sync_reg;
      send_prev_reg <= ctrl_io_send;
    end
  end

  // -------------------------------------------------------------------------
  // RX FSM, byte packing and BRAM write
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_reg   <= RX_IDLE;
      rx_cnt_reg     <= '0;
      rx_bit_reg     <= '0;
      rx_shift_reg   <= '0;
      byte_phase_reg <= 1'b0;
      low_byte_reg   <= '0;
      wr_ptr_reg     <= '0;
      wr_addr_reg    <= '0;
      word_cnt_reg   <= '0;
      data_out_reg   <= '0;
      we_reg         <= 1'b0;
    end else begin
      we_reg <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          // Only new frames are gated; a frame already started always finishes.
          if (ctrl_io_receive && (tx_state_reg == TX_IDLE) && rx_prev_reg && !rx_sync_reg) begin
            rx_state_reg <= RX_START;
            rx_cnt_reg   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_reg == HALF_LAST) begin
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            // Line back high at mid start bit means it was a glitch.
            rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= rx_byte;
            if (rx_bit_reg == 3'd7) rx_state_reg <= RX_STOP;
            else                    rx_bit_reg   <= rx_bit_reg + 1'b1;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_state_reg <= RX_IDLE;
            // A low stop bit is a framing error: the byte is silently dropped.
            if (rx_sync_reg) begin
              if (!byte_phase_reg) begin
                low_byte_reg   <= rx_shift_reg;
                byte_phase_reg <= 1'b1;
              end else begin
                data_out_reg   <= {rx_shift_reg, low_byte_reg};
                wr_addr_reg    <= wr_ptr_reg;
                we_reg         <= 1'b1;
                wr_ptr_reg     <= wr_ptr_reg + 1'b1;
                byte_phase_reg <= 1'b0;
                if (!word_cnt_reg[ADDR_W]) word_cnt_reg <= word_cnt_reg + 1'b1;
              end
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // TX FSM: read word, send low byte then high byte, advance read pointer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_reg   <= TX_IDLE;
      tx_cnt_reg     <= '0;
      tx_bit_reg     <= '0;
      tx_shift_reg   <= '0;
      tx_hi_byte_reg <= '0;
      tx_hi_sel_reg  <= 1'b0;
      rd_ptr_reg     <= '0;
      tx_reg         <= 1'b1;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          tx_reg <= 1'b1;
          if (send_rise && (rx_state_reg == RX_IDLE) && (word_cnt_reg != '0)) begin
            rd_ptr_reg   <= '0;
            tx_state_reg <= TX_READ;
          end
        end
        // Address is presented here; BRAM returns data on the following cycle.
        TX_READ: tx_state_reg <= TX_LATCH;
        TX_LATCH: begin
          tx_shift_reg   <= data_in_io[7:0];
          tx_hi_byte_reg <= data_in_io[15:8];
          tx_hi_sel_reg  <= 1'b0;
          tx_cnt_reg     <= '0;
          tx_reg         <= 1'b0;
          tx_state_reg   <= TX_START;
        end
        TX_START: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_reg       <= tx_shift_reg[0];
            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
            tx_state_reg <= TX_DATA;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg <= '0;
            if (tx_bit_reg == 3'd7) begin
              tx_reg       <= 1'b1;
              tx_state_reg <= TX_STOP;
            end else begin
              tx_reg       <= tx_shift_reg[0];
              tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
              tx_bit_reg   <= tx_bit_reg + 1'b1;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg <= '0;
            if (!tx_hi_sel_reg) begin
              tx_hi_sel_reg <= 1'b1;
              tx_shift_reg  <= tx_hi_byte_reg;
              tx_reg        <= 1'b0;
              tx_state_reg  <= TX_START;
            end else begin
              rd_ptr_reg   <= rd_next;
              tx_state_reg <= (rd_next == word_cnt_reg) ? TX_IDLE : TX_READ;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + 1'b1;
          end
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

  assign tx          = tx_reg;
  assign we_io       = we_reg;
  assign data_out_io = data_out_reg;
  assign addr_io     = (tx_state_reg != TX_IDLE) ? rd_ptr_reg[ADDR_W-1:0] : wr_addr_reg;
  assign led_rx      = (rx_state_reg != RX_IDLE);
  assign led_tx      = (tx_state_reg != TX_IDLE);

endmodule

// File: tb/tb_uart_io_module.sv
// ---------------------------------------------------------------------------
// tb_uart_io_module
//   Directed bench for uart_io_module with a behavioural BRAM. Expected BRAM
//   writes and expected transmitted bytes are queued when stimulus is driven
//   and consumed by monitors watching we_io and tx.
// ---------------------------------------------------------------------------
module tb_uart_io_module;
  localparam int CPB = 87;

  logic        clk_100 = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        tx;
  logic [15:0] data_in_io;
  logic [15:0] data_out_io;
  logic [15:0] addr_io;
  logic        we_io;
  logic        ctrl_io_receive = 1'b0;
  logic        ctrl_io_send = 1'b0;
  logic        led_rx, led_tx;

  logic [15:0] bram [0:65535];
  logic [31:0] wr_q [$];
  logic [7:0]  tx_q [$];
  int          checks = 0;
  int          errors = 0;
  bit          tx_mon_en = 1'b1;

  always #50 clk_100 = ~clk_100;

  uart_io_module #(.CLKS_PER_BIT(CPB), .ADDR_W(16)) dut (
    .clk_100(clk_100), .rst_n(rst_n), .rx(rx), .tx(tx),
    .data_in_io(data_in_io), .data_out_io(data_out_io), .addr_io(addr_io),
    .we_io(we_io), .ctrl_io_receive(ctrl_io_receive), .ctrl_io_send(ctrl_io_send),
    .led_rx(led_rx), .led_tx(led_tx)
  );

  // Single-port BRAM, registered read
  always @(posedge clk_100) begin
    if (we_io) bram[addr_io] <= data_out_io;
    data_in_io <= bram[addr_io];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // BRAM write monitor
  always @(negedge clk_100) begin
    logic [31:0] exp_w;
    if (rst_n && we_io) begin
      checks++;
      assert (wr_q.size() != 0) else begin
        errors++;
        $error("FAIL write_unexpected: got addr=%0h data=%0h, expected no write", addr_io, data_out_io);
      end
      if (wr_q.size() != 0) begin
        exp_w = wr_q.pop_front();
        $display("write addr=%04h data=%04h", addr_io, data_out_io);
        chk("write_addr_data", {addr_io, data_out_io}, exp_w);
      end
    end
  end

  // TX frame decoder
  always begin
    logic       tx_prev;
    logic [7:0] got_b;
    logic [7:0] exp_b;
    tx_prev = 1'b1;
    forever begin
      @(negedge clk_100);
      if (tx_mon_en && rst_n && tx_prev && !tx) begin
        repeat (CPB / 2) @(negedge clk_100);
        chk("tx_start_bit", tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk_100);
          got_b[i] = tx;
        end
        repeat (CPB) @(negedge clk_100);
        chk("tx_stop_bit", tx, 1'b1);
        checks++;
        assert (tx_q.size() != 0) else begin
          errors++;
          $error("FAIL tx_unexpected_frame: got %0h, expected no frame", got_b);
        end
        if (tx_q.size() != 0) begin
          exp_b = tx_q.pop_front();
          $display("tx byte=%02h", got_b);
          chk("tx_byte", got_b, exp_b);
        end
      end
      tx_prev = tx;
    end
  end

  // Drive one 8N1 frame on rx; led_rx is checked part way through the frame.
  task automatic uart_rx_byte(input logic [7:0] b, input logic stop_bit, input logic exp_led);
    @(negedge clk_100);
    rx = 1'b0;
    repeat (CPB) @(negedge clk_100);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk_100);
      if (i == 3) chk("led_rx_mid_frame", led_rx, exp_led);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk_100);
    rx = 1'b1;
    repeat (20) @(negedge clk_100);
  endtask

  initial begin
    int cnt;
    int bad;
    repeat (5) @(negedge clk_100);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_100);

    // Reset state
    chk("reset_tx", tx, 1'b1);
    chk("reset_we", we_io, 1'b0);
    chk("reset_addr", addr_io, 16'h0000);
    chk("reset_data_out", data_out_io, 16'h0000);
    chk("reset_led_rx", led_rx, 1'b0);
    chk("reset_led_tx", led_tx, 1'b0);

    // Send edge with zero stored words must be ignored
    ctrl_io_send = 1'b1;
    bad = 0;
    repeat (2 * CPB) begin
      @(negedge clk_100);
      if (!tx || led_tx) bad++;
    end
    chk("send_empty_ignored", bad, 0);
    ctrl_io_send = 1'b0;

    // Receive two words
    ctrl_io_receive = 1'b1;
    repeat (5) @(negedge clk_100);
    wr_q.push_back({16'h0000, 16'hF00F});
    uart_rx_byte(8'h0F, 1'b1, 1'b1);
    uart_rx_byte(8'hF0, 1'b1, 1'b1);
    chk("word0_written", wr_q.size(), 0);
    wr_q.push_back({16'h0001, 16'h5555});
    uart_rx_byte(8'h55, 1'b1, 1'b1);
    uart_rx_byte(8'h55, 1'b1, 1'b1);
    chk("word1_written", wr_q.size(), 0);

    // Framing error: byte dropped, no write
    uart_rx_byte(8'h33, 1'b0, 1'b1);
    chk("framing_no_write", wr_q.size(), 0);

    // Short glitch on rx must not start a byte
    @(negedge clk_100);
    rx = 1'b0;
    repeat (10) @(negedge clk_100);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk_100);
    chk("glitch_led_rx_idle", led_rx, 1'b0);

    // Next good pair still packs at the next address
    wr_q.push_back({16'h0002, 16'h3CA5});
    uart_rx_byte(8'hA5, 1'b1, 1'b1);
    uart_rx_byte(8'h3C, 1'b1, 1'b1);
    chk("word2_written", wr_q.size(), 0);

    // Odd trailing byte is held, never written
    uart_rx_byte(8'h77, 1'b1, 1'b1);
    chk("odd_byte_no_write", wr_q.size(), 0);

    // Receive disabled: frame ignored
    ctrl_io_receive = 1'b0;
    repeat (5) @(negedge clk_100);
    uart_rx_byte(8'h99, 1'b1, 1'b0);
    chk("rx_disabled_no_write", wr_q.size(), 0);

    // Transmit session: all three stored words, low byte first
    tx_q.push_back(8'h0F); tx_q.push_back(8'hF0);
    tx_q.push_back(8'h55); tx_q.push_back(8'h55);
    tx_q.push_back(8'hA5); tx_q.push_back(8'h3C);
    ctrl_io_send = 1'b1;
    repeat (2) @(negedge clk_100);
    chk("led_tx_session_start", led_tx, 1'b1);
    cnt = 0;
    bad = 0;
    while (tx_q.size() != 0 && cnt < 8000) begin
      @(negedge clk_100);
      cnt++;
      if (!led_tx) bad++;
      if (cnt == 2000) ctrl_io_send = 1'b0;   // re-trigger mid session, must be ignored
      if (cnt == 2010) ctrl_io_send = 1'b1;
    end
    chk("tx_all_bytes_sent", tx_q.size(), 0);
    chk("led_tx_held_high", bad, 0);
    repeat (CPB + 10) @(negedge clk_100);
    chk("tx_idle_after_session", tx, 1'b1);
    chk("led_tx_low_after_session", led_tx, 1'b0);

    // Reset in the middle of a new session
    tx_mon_en = 1'b0;
    ctrl_io_send = 1'b0;
    repeat (5) @(negedge clk_100);
    ctrl_io_send = 1'b1;
    cnt = 0;
    while (tx && cnt < 20) begin
      @(negedge clk_100);
      cnt++;
    end
    chk("abort_session_started", tx, 1'b0);
    repeat (3 * CPB) @(negedge clk_100);
    rst_n = 1'b0;
    #1;
    chk("abort_tx_high", tx, 1'b1);
    chk("abort_led_tx_low", led_tx, 1'b0);
    chk("abort_addr_zero", addr_io, 16'h0000);
    repeat (3) @(negedge clk_100);
    rst_n = 1'b1;
    ctrl_io_send = 1'b0;
    repeat (5) @(negedge clk_100);
    ctrl_io_send = 1'b1;   // word count cleared by reset, so no session
    bad = 0;
    repeat (30 * CPB) begin
      @(negedge clk_100);
      if (!tx || led_tx) bad++;
    end
    chk("no_frames_after_abort", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
